// File: rtl/alu_op_sequencer.sv
// Purpose: multi-cycle control FSM that steps one register-to-register ALU instruction through the shared bus/ALU datapath.
// Latency: done is high in the 4th cycle after the accepting start edge (5th for mul/div); one instruction in flight at a time.
// Backpressure: start is only sampled in IDLE; a start seen while busy (including DONE) is dropped, never queued.
module alu_op_sequencer #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rc,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              rd_en,
  output logic [REG_AW-1:0] rd_sel,
  output logic              y_in,
  output logic [3:0]        alu_select,
  output logic              zlo_out,
  output logic              zhi_out,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_sel,
  output logic              lo_in,
  output logic              hi_in,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Y = 3'd1,
    S_EXEC   = 3'd2,
    S_WB_LO  = 3'd3,
    S_WB_HI  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Opcode classes. Anything not listed is rejected with an illegal pulse.
  function automatic logic is_legal(input logic [3:0] o);
    case (o)
      4'b0001, 4'b0010, 4'b0011, 4'b0101,
      4'b0110, 4'b0111, 4'b1000, 4'b1010,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: is_legal = 1'b1;
      default:                             is_legal = 1'b0;
    endcase
  endfunction

  // Unary ops (neg, not) take only Y; no second operand is put on the bus.
  function automatic logic is_unary(input logic [3:0] o);
    is_unary = (o == 4'b1000) || (o == 4'b1010);
  endfunction

  // Wide ops (mul, div) produce a 64-bit result that goes to LO then HI.
  function automatic logic is_wide(input logic [3:0] o);
    is_wide = (o == 4'b0011) || (o == 4'b0101);
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [REG_AW-1:0]   ra_q, ra_d;
  logic [REG_AW-1:0]   rc_q, rc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic                rd_en_q, rd_en_d;
  logic [REG_AW-1:0]   rd_sel_q, rd_sel_d;
  logic                y_in_q, y_in_d;
  logic [3:0]          alu_select_q, alu_select_d;
  logic                zlo_out_q, zlo_out_d;
  logic                zhi_out_q, zhi_out_d;
  logic                wr_en_q, wr_en_d;
  logic [REG_AW-1:0]   wr_sel_q, wr_sel_d;
  logic                lo_in_q, lo_in_d;
  logic                hi_in_q, hi_in_d;

  // Next state plus the strobes of the state being entered, so every output is a flop.
  // Each state has at most one bus driver (rd_en, zlo_out or zhi_out), never two.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ra_d         = ra_q;
    rc_d         = rc_q;
    cnt_d        = cnt_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    rd_en_d      = 1'b0;
    rd_sel_d     = '0;
    y_in_d       = 1'b0;
    alu_select_d = 4'b0000;
    zlo_out_d    = 1'b0;
    zhi_out_d    = 1'b0;
    wr_en_d      = 1'b0;
    wr_sel_d     = '0;
    lo_in_d      = 1'b0;
    hi_in_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_legal(op)) begin
            // rb is consumed immediately by the LOAD_Y strobes, so it needs no holding register.
            op_d     = op;
            ra_d     = ra;
            rc_d     = rc;
            state_d  = S_LOAD_Y;
            busy_d   = 1'b1;
            rd_en_d  = 1'b1;
            rd_sel_d = rb;
            y_in_d   = 1'b1;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end

      S_LOAD_Y: begin
        state_d      = S_EXEC;
        busy_d       = 1'b1;
        alu_select_d = op_q;
        if (!is_unary(op_q)) begin
          rd_en_d  = 1'b1;
          rd_sel_d = rc_q;
        end
      end

      S_EXEC: begin
        state_d   = S_WB_LO;
        busy_d    = 1'b1;
        zlo_out_d = 1'b1;
        if (is_wide(op_q)) begin
          lo_in_d = 1'b1;
        end else begin
          wr_en_d  = 1'b1;
          wr_sel_d = ra_q;
        end
      end

      S_WB_LO: begin
        busy_d = 1'b1;
        if (is_wide(op_q)) begin
          state_d   = S_WB_HI;
          zhi_out_d = 1'b1;
          hi_in_d   = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      S_WB_HI: begin
        state_d = S_DONE;
        busy_d  = 1'b1;
        done_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, captured fields, counter and output strobes; clr wins over every transition.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= S_IDLE;
      op_q         <= 4'b0000;
      ra_q         <= '0;
      rc_q         <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_sel_q     <= '0;
      y_in_q       <= 1'b0;
      alu_select_q <= 4'b0000;
      zlo_out_q    <= 1'b0;
      zhi_out_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= '0;
      lo_in_q      <= 1'b0;
      hi_in_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ra_q         <= ra_d;
      rc_q         <= rc_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      rd_en_q      <= rd_en_d;
      rd_sel_q     <= rd_sel_d;
      y_in_q       <= y_in_d;
      alu_select_q <= alu_select_d;
      zlo_out_q    <= zlo_out_d;
      zhi_out_q    <= zhi_out_d;
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      lo_in_q      <= lo_in_d;
      hi_in_q      <= hi_in_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign rd_en      = rd_en_q;
  assign rd_sel     = rd_sel_q;
  assign y_in       = y_in_q;
  assign alu_select = alu_select_q;
  assign zlo_out    = zlo_out_q;
  assign zhi_out    = zhi_out_q;
  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign lo_in      = lo_in_q;
  assign hi_in      = hi_in_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: scoreboard bench for alu_op_sequencer; the driver queues the per-cycle strobe pattern of each instruction.
// Latency: a negedge monitor pops one expected pattern for every cycle the DUT is busy or pulses illegal.
// Backpressure: the driver honours the 5/6-cycle instruction spacing and deliberately pokes start while busy.
module tb_alu_op_sequencer;

  localparam int REG_AW = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic [3:0]        op;
  logic [REG_AW-1:0] ra, rb, rc;
  logic              busy, done, illegal, rd_en, y_in;
  logic              zlo_out, zhi_out, wr_en, lo_in, hi_in;
  logic [REG_AW-1:0] rd_sel, wr_sel;
  logic [3:0]        alu_select;
  logic [CNT_W-1:0]  op_count;

  alu_op_sequencer #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .busy(busy), .done(done), .illegal(illegal), .rd_en(rd_en), .rd_sel(rd_sel),
    .y_in(y_in), .alu_select(alu_select), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .wr_en(wr_en), .wr_sel(wr_sel), .lo_in(lo_in), .hi_in(hi_in), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]        tag;
    logic              busy;
    logic              done;
    logic              illegal;
    logic              rd_en;
    logic [REG_AW-1:0] rd_sel;
    logic              y_in;
    logic [3:0]        alu_select;
    logic              zlo;
    logic              zhi;
    logic              wr_en;
    logic [REG_AW-1:0] wr_sel;
    logic              lo;
    logic              hi;
    logic              chk_cnt;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] cnt_model = '0;
  logic [7:0]       tag_n = 8'd0;
  bit               mon_en = 1'b0;
  bit               mid_instr = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Issue one legal instruction; queue its per-cycle patterns (only LOAD_Y/EXEC if trunc).
  task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input bit trunc);
    exp_t e;
    bit wide, un;
    wide = (o == 4'b0011) || (o == 4'b0101);
    un   = (o == 4'b1000) || (o == 4'b1010);
    tag_n++;
    start = 1'b1; op = o; ra = a; rb = b; rc = c;
    e = '0; e.tag = tag_n; e.busy = 1; e.rd_en = 1; e.rd_sel = b; e.y_in = 1;
    e.chk_cnt = 1; e.cnt = cnt_model;
    exp_q.push_back(e);
    e = '0; e.tag = tag_n; e.busy = 1; e.alu_select = o; e.rd_en = !un; e.rd_sel = c;
    exp_q.push_back(e);
    if (!trunc) begin
      e = '0; e.tag = tag_n; e.busy = 1; e.zlo = 1;
      if (wide) e.lo = 1;
      else begin e.wr_en = 1; e.wr_sel = a; end
      exp_q.push_back(e);
      if (wide) begin
        e = '0; e.tag = tag_n; e.busy = 1; e.zhi = 1; e.hi = 1;
        exp_q.push_back(e);
      end
      e = '0; e.tag = tag_n; e.busy = 1; e.done = 1;
      exp_q.push_back(e);
      cnt_model++;
    end
    @(posedge clk); #1;
    // Scramble inputs after acceptance: the DUT must work from its captured copy.
    start = 1'b0; op = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
  endtask

  task automatic issue_illegal(input logic [3:0] o);
    exp_t e;
    tag_n++;
    start = 1'b1; op = o;
    e = '0; e.tag = tag_n; e.illegal = 1; e.chk_cnt = 1; e.cnt = cnt_model;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: compare every busy/illegal cycle against the queue; idle cycles must be silent.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy || illegal) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: busy=%0b illegal=%0b done=%0b with empty queue",
                   busy, illegal, done);
        end else begin
          exp_t e, a;
          e = exp_q.pop_front();
          a = '0;
          a.tag = e.tag; a.busy = busy; a.done = done; a.illegal = illegal;
          a.rd_en = rd_en; a.rd_sel = rd_en ? rd_sel : 4'h0; a.y_in = y_in;
          a.alu_select = alu_select; a.zlo = zlo_out; a.zhi = zhi_out;
          a.wr_en = wr_en; a.wr_sel = wr_sel; a.lo = lo_in; a.hi = hi_in;
          a.chk_cnt = e.chk_cnt; a.cnt = e.chk_cnt ? op_count : e.cnt;
          if (!e.rd_en) a.rd_sel = e.rd_sel;
          if (!e.wr_en) a.wr_sel = e.wr_sel;
          checks++;
          if (a !== e) begin
            errors++;
            $display("FAIL cycle_out tag %0d: got %h expected %h", e.tag, a, e);
          end
          mid_instr = e.busy && !e.done;
        end
      end else begin
        checks++;
        if ({done, rd_en, rd_sel, y_in, alu_select, zlo_out, zhi_out, wr_en, wr_sel, lo_in, hi_in} !== '0) begin
          errors++;
          $display("FAIL idle_quiet: rd_en=%0b alu_select=%b wr_en=%0b zlo=%0b zhi=%0b done=%0b expected all 0",
                   rd_en, alu_select, wr_en, zlo_out, zhi_out, done);
        end
        if (mid_instr) begin
          checks++; errors++;
          $display("FAIL gap: busy dropped mid-instruction, expected busy=1");
          mid_instr = 1'b0;
        end
      end
      if (!clr) mid_instr = 1'b0;
    end
  end

  initial begin
    clr = 1'b0; start = 1'b0; op = 4'h0; ra = 4'h0; rb = 4'h0; rc = 4'h0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    mon_en = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_op_count", op_count, 0);
    check("reset_alu_select", alu_select, 0);

    // add r1 <- r2 + r3
    issue(4'b0001, 4'd1, 4'd2, 4'd3, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("add_op_count", op_count, 1);
    // mul, back to back with the add slot spacing
    issue(4'b0011, 4'd9, 4'd4, 4'd5, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("mul_op_count", op_count, 2);
    // not r6 <- ~r7 (unary)
    issue(4'b1010, 4'd6, 4'd7, 4'd0, 1'b0);
    repeat (4) @(posedge clk); #1;

    // rejected opcode, then a legal start in the illegal-pulse cycle
    issue_illegal(4'b1001);
    issue(4'b0110, 4'd2, 4'd3, 4'd4, 1'b0);
    repeat (4) @(posedge clk); #1;
    issue_illegal(4'b0000);
    repeat (2) @(posedge clk); #1;
    check("illegal_op_count", op_count, 4);

    // start held while busy must be dropped: only one done
    issue(4'b0001, 4'd8, 4'd10, 4'd11, 1'b0);
    start = 1'b1; op = 4'b0010; ra = 4'd15; rb = 4'd14; rc = 4'd13;
    repeat (4) @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("busy_start_op_count", op_count, 5);

    // reset mid-EXEC of an add: no writeback, counter cleared
    issue(4'b0001, 4'd1, 4'd2, 4'd3, 1'b1);
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (2) @(posedge clk); #1;
    clr = 1'b1;
    cnt_model = '0;
    check("midreset_op_count", op_count, 0);
    check("midreset_busy", busy, 0);
    repeat (4) @(posedge clk); #1;
    check("midreset_no_late_wr", wr_en, 0);

    // nine back-to-back ops; 3-bit counter wraps to 1
    for (int i = 0; i < 9; i++) begin
      logic [3:0] ops [0:8];
      ops = '{4'b0001, 4'b0010, 4'b0101, 4'b0111, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
      issue(ops[i], 4'(i), 4'(i + 1), 4'(i + 2), 1'b0);
      if (ops[i] == 4'b0101) repeat (5) @(posedge clk);
      else                   repeat (4) @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk); #1;
    check("wrap_op_count", op_count, 1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
